// File: rtl/fft_sequencer_if.sv
// Handshake and memory/engine buses between the FFT sequencer and its environment.
// The master side is the sequencer; the slave side is the testbench or top level.
interface fft_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              i_start;
  logic              i_abort;
  logic [2:0]        i_point_configuration;
  logic              i_in_valid;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data;
  logic              o_sram_wr_en;
  logic [9:0]        o_sram_wr_addr;
  logic [DATA_W-1:0] o_sram_wr_data;
  logic              o_sram_rd_en;
  logic [9:0]        o_sram_rd_addr;
  logic              o_sram_rd_bank;
  logic [DATA_W-1:0] i_sram_rd_data;
  logic              o_engine_resetn;
  logic [2:0]        o_engine_cfg;
  logic              o_working;
  logic              i_fft_done;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [DATA_W-1:0] o_out_data;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_start, i_abort, i_point_configuration, i_in_valid, i_in_data,
           i_sram_rd_data, i_fft_done, i_out_ready,
    output o_in_ready, o_sram_wr_en, o_sram_wr_addr, o_sram_wr_data,
           o_sram_rd_en, o_sram_rd_addr, o_sram_rd_bank, o_engine_resetn,
           o_engine_cfg, o_working, o_out_valid, o_out_data, o_busy, o_done
  );

  modport slave (
    output i_start, i_abort, i_point_configuration, i_in_valid, i_in_data,
           i_sram_rd_data, i_fft_done, i_out_ready,
    input  o_in_ready, o_sram_wr_en, o_sram_wr_addr, o_sram_wr_data,
           o_sram_rd_en, o_sram_rd_addr, o_sram_rd_bank, o_engine_resetn,
           o_engine_cfg, o_working, o_out_valid, o_out_data, o_busy, o_done
  );
endinterface

// File: rtl/fft_sequencer.sv
// Sequences one FFT: load samples into bank 0, hold the stage engine in reset until
// the load settles, then stream the result bank out through a 2-entry FIFO.
//
// state   | meaning
// IDLE    | waiting for i_start
// LOAD    | accepting N input samples into bank 0
// COMPUTE | engine released one cycle after entry, waiting for i_fft_done
// UNLOAD  | reading N results from the final bank and streaming them out
module fft_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          i_resetn,
  fft_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

  state_t            state_q;
  logic [2:0]        cfg_q;
  logic [10:0]       n_pts;
  logic [10:0]       load_cnt_q;
  logic [10:0]       rd_cnt_q;
  logic [10:0]       out_cnt_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [9:0]        wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              eng_rstn_q;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              head_q;
  logic [1:0]        fifo_cnt_q;

  logic              in_hs;
  logic              abort_now;
  logic              pop;
  logic [2:0]        occ_next;
  logic              issue;
  logic              last_pop;
  logic              slot;

  assign n_pts     = 11'd8 << cfg_q;
  assign in_hs     = in_ready_q & bus.i_in_valid;
  assign abort_now = bus.i_abort & (state_q != IDLE);
  assign pop       = (fifo_cnt_q != 2'd0) & bus.i_out_ready;
  // Slots committed after this edge: current entries, the read in flight, minus a pop.
  assign occ_next  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == UNLOAD) & ~bus.i_abort & (occ_next < 3'd2) &
                     (rd_cnt_q < n_pts);
  assign last_pop  = (state_q == UNLOAD) & pop & (out_cnt_q == n_pts - 11'd1);
  assign slot      = head_q ^ fifo_cnt_q[0];

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= IDLE;
      cfg_q      <= 3'd0;
      load_cnt_q <= 11'd0;
      rd_cnt_q   <= 11'd0;
      out_cnt_q  <= 11'd0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 10'd0;
      wr_data_q  <= '0;
      eng_rstn_q <= 1'b0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      head_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      wr_en_q    <= in_hs;
      inflight_q <= issue;
      if (in_hs) begin
        wr_addr_q <= load_cnt_q[9:0];
        wr_data_q <= bus.i_in_data;
      end
      if (inflight_q) fifo_q[slot] <= bus.i_sram_rd_data;
      if (pop) head_q <= ~head_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      if (issue) rd_cnt_q <= rd_cnt_q + 11'd1;
      if (pop) out_cnt_q <= out_cnt_q + 11'd1;

      if (abort_now) begin
        state_q    <= IDLE;
        load_cnt_q <= 11'd0;
        rd_cnt_q   <= 11'd0;
        out_cnt_q  <= 11'd0;
        in_ready_q <= 1'b0;
        wr_en_q    <= 1'b0;
        eng_rstn_q <= 1'b0;
        inflight_q <= 1'b0;
        head_q     <= 1'b0;
        fifo_cnt_q <= 2'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.i_start) begin
              state_q    <= LOAD;
              cfg_q      <= bus.i_point_configuration;
              in_ready_q <= 1'b1;
              load_cnt_q <= 11'd0;
              rd_cnt_q   <= 11'd0;
              out_cnt_q  <= 11'd0;
              head_q     <= 1'b0;
              fifo_cnt_q <= 2'd0;
            end
          end
          LOAD: begin
            if (in_hs) begin
              load_cnt_q <= load_cnt_q + 11'd1;
              if (load_cnt_q == n_pts - 11'd1) begin
                state_q    <= COMPUTE;
                in_ready_q <= 1'b0;
              end
            end
          end
          COMPUTE: begin
            // The final bank-0 write lands in the first COMPUTE cycle, before release.
            if (!eng_rstn_q) begin
              eng_rstn_q <= 1'b1;
            end else if (bus.i_fft_done) begin
              eng_rstn_q <= 1'b0;
              state_q    <= UNLOAD;
            end
          end
          UNLOAD: begin
            if (last_pop) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_in_ready      = in_ready_q;
  assign bus.o_sram_wr_en    = wr_en_q;
  assign bus.o_sram_wr_addr  = wr_addr_q;
  assign bus.o_sram_wr_data  = wr_data_q;
  assign bus.o_sram_rd_en    = issue;
  assign bus.o_sram_rd_addr  = rd_cnt_q[9:0];
  // Odd stage counts (cfg+3) finish in bank 1.
  assign bus.o_sram_rd_bank  = (state_q != IDLE) & ~cfg_q[0];
  assign bus.o_engine_resetn = eng_rstn_q;
  assign bus.o_engine_cfg    = cfg_q;
  assign bus.o_working       = eng_rstn_q & ~bus.i_fft_done;
  assign bus.o_out_valid     = (fifo_cnt_q != 2'd0);
  assign bus.o_out_data      = fifo_q[head_q];
  assign bus.o_busy          = (state_q != IDLE);
  assign bus.o_done          = last_pop & ~bus.i_abort;
endmodule

// File: tb/tb_fft_sequencer.sv
// Randomized bench for fft_sequencer: drives load/compute/unload runs, aborts and
// resets, and checks writes and the result stream against a model of the two banks.
module tb_fft_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem  [2][1024];
  logic [31:0] sent [1024];
  int          wr_idx = 0;

  always #5 clk = ~clk;

  fft_sequencer_if #(.DATA_W(32)) bus ();
  fft_sequencer #(.DATA_W(32)) dut (.clk(clk), .i_resetn(resetn), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single-cycle-latency SRAM read port; junk when not enabled.
  always @(posedge clk)
    bus.i_sram_rd_data <= bus.o_sram_rd_en ? mem[bus.o_sram_rd_bank][bus.o_sram_rd_addr]
                                           : $urandom;

  // Bank-0 writes must arrive in natural order carrying the accepted samples.
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.o_sram_wr_en === 1'b1) begin
      check("wr_addr", 64'(bus.o_sram_wr_addr), 64'(wr_idx));
      if (wr_idx < 1024) check("wr_data", 64'(bus.o_sram_wr_data), 64'(sent[wr_idx]));
      mem[0][bus.o_sram_wr_addr] = bus.o_sram_wr_data;
      wr_idx++;
    end
  end

  task automatic start_run(input logic [2:0] cfg);
    bus.i_start = 1'b1;
    bus.i_point_configuration = cfg;
    wr_idx = 0;
    tick;
    bus.i_start = 1'b0;
    bus.i_point_configuration = 3'($urandom);
    check("busy_load", 64'(bus.o_busy), 64'd1);
    check("engine_cfg", 64'(bus.o_engine_cfg), 64'(cfg));
  endtask

  task automatic load(input int n, input int m, input int gap_pct);
    int got = 0;
    int cyc = 0;
    while (got < m && cyc < 20 * n + 50) begin
      bus.i_in_valid = ($urandom_range(99) >= gap_pct);
      bus.i_in_data  = $urandom;
      if (bus.i_in_valid) sent[got] = bus.i_in_data;
      #1;
      if (cyc < 4 || got == m - 1) begin
        check("in_ready", 64'(bus.o_in_ready), 64'd1);
        check("eng_rstn_load", 64'(bus.o_engine_resetn), 64'd0);
      end
      if (bus.i_in_valid) got++;
      tick;
      cyc++;
    end
    bus.i_in_valid = 1'b0;
    if (got < m) check("load_timeout", 64'(got), 64'(m));
    if (m == n) begin
      check("in_ready_after", 64'(bus.o_in_ready), 64'd0);
      check("eng_rstn_first", 64'(bus.o_engine_resetn), 64'd0);
      tick;
      check("eng_rstn_rise", 64'(bus.o_engine_resetn), 64'd1);
      check("working", 64'(bus.o_working), 64'd1);
    end
  endtask

  task automatic compute(input int n, input logic bank, input int delay);
    for (int i = 0; i < n; i++) mem[bank][i] = $urandom;
    for (int d = 0; d < delay; d++) begin
      bus.i_fft_done = 1'b0;
      #1;
      if (d < 3) check("working_hi", 64'(bus.o_working), 64'd1);
      tick;
    end
    bus.i_fft_done = 1'b1;
    #1;
    check("working_lo", 64'(bus.o_working), 64'd0);
    tick;
    bus.i_fft_done = 1'b0;
    check("eng_rstn_unload", 64'(bus.o_engine_resetn), 64'd0);
    check("busy_unload", 64'(bus.o_busy), 64'd1);
  endtask

  task automatic unload(input int n, input logic bank, input int pct, input int abort_after);
    int idx = 0;
    int issued = 0;
    int cyc = 0;
    while (idx < n && cyc < 20 * n + 50) begin
      bus.i_out_ready = ($urandom_range(99) < pct);
      if (idx == abort_after) begin
        bus.i_abort = 1'b1;
        bus.i_out_ready = 1'b0;
      end
      #1;
      if (bus.o_sram_rd_en) begin
        check("rd_addr", 64'(bus.o_sram_rd_addr), 64'(issued));
        check("rd_bank", 64'(bus.o_sram_rd_bank), 64'(bank));
        issued++;
      end
      if (bus.o_out_valid && bus.i_out_ready) begin
        check("out_data", 64'(bus.o_out_data), 64'(mem[bank][idx]));
        check("done_pulse", 64'(bus.o_done), 64'(idx == n - 1));
        if (pct == 100 && idx == 0) check("first_latency", 64'(cyc), 64'd2);
        idx++;
      end else begin
        check("done_idle", 64'(bus.o_done), 64'd0);
      end
      check("fifo_bound", 64'((issued - idx) <= 2), 64'd1);
      if (bus.i_abort) begin
        tick;
        bus.i_abort = 1'b0;
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        check("abort_valid", 64'(bus.o_out_valid), 64'd0);
        check("abort_done", 64'(bus.o_done), 64'd0);
        return;
      end
      tick;
      cyc++;
    end
    bus.i_out_ready = 1'b0;
    check("out_count", 64'(idx), 64'(n));
    if (pct == 100) check("unload_cycles", 64'(cyc), 64'(n + 2));
    check("busy_end", 64'(bus.o_busy), 64'd0);
    check("done_end", 64'(bus.o_done), 64'd0);
  endtask

  task automatic run(input logic [2:0] cfg, input int gap, input int delay, input int pct);
    int n = 8 << cfg;
    start_run(cfg);
    load(n, n, gap);
    compute(n, ~cfg[0], delay);
    unload(n, ~cfg[0], pct, -1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(bus.o_busy), 64'd0);
    check({tag, "_ctl"},   64'({bus.o_in_ready, bus.o_sram_wr_en, bus.o_sram_rd_en,
                                bus.o_working, bus.o_out_valid, bus.o_done,
                                bus.o_engine_resetn, bus.o_sram_rd_bank}), 64'd0);
    check({tag, "_addr"},  64'({bus.o_sram_wr_addr, bus.o_sram_rd_addr, bus.o_engine_cfg}), 64'd0);
    check({tag, "_data"},  64'({bus.o_sram_wr_data, bus.o_out_data}), 64'd0);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_point_configuration = 3'd0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data = '0;
    bus.i_fft_done = 1'b0;
    bus.i_out_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 1024; i++) mem[b][i] = '0;
    #1;
    check_all_zero("reset");
    tick;
    tick;
    resetn = 1'b1;
    tick;
    check("idle_busy", 64'(bus.o_busy), 64'd0);

    // Abort ignored in IDLE
    bus.i_abort = 1'b1;
    tick;
    bus.i_abort = 1'b0;
    check("abort_idle", 64'(bus.o_busy), 64'd0);

    run(3'd0, 0, 10, 100);
    run(3'd7, 0, 100, 100);
    run(3'd2, 30, 20, 50);

    // Abort during LOAD after 5 samples, then a fresh load from address 0
    start_run(3'd1);
    load(16, 5, 0);
    bus.i_abort = 1'b1;
    #1;
    check("abort_load_done", 64'(bus.o_done), 64'd0);
    tick;
    bus.i_abort = 1'b0;
    check("abort_load_busy", 64'(bus.o_busy), 64'd0);
    check("abort_load_ready", 64'(bus.o_in_ready), 64'd0);
    run(3'd0, 20, 5, 80);

    // Abort during UNLOAD after 3 outputs
    start_run(3'd1);
    load(16, 16, 10);
    compute(16, 1'b0, 8);
    unload(16, 1'b0, 100, 3);
    run(3'd3, 25, 12, 70);

    // Start held through COMPUTE; abort and fft_done in the same cycle
    start_run(3'd0);
    load(8, 8, 0);
    bus.i_start = 1'b1;
    for (int d = 0; d < 5; d++) tick;
    check("start_in_compute", 64'(bus.o_busy), 64'd1);
    bus.i_abort = 1'b1;
    bus.i_fft_done = 1'b1;
    tick;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_fft_done = 1'b0;
    #1;
    check("abort_wins_busy", 64'(bus.o_busy), 64'd0);
    check("abort_wins_eng", 64'(bus.o_engine_resetn), 64'd0);
    tick;
    check("abort_wins_idle", 64'(bus.o_busy), 64'd0);

    // Asynchronous reset mid-UNLOAD, then a clean run
    start_run(3'd2);
    load(32, 32, 0);
    compute(32, 1'b1, 6);
    bus.i_out_ready = 1'b1;
    for (int d = 0; d < 6; d++) tick;
    check("pre_reset_valid", 64'(bus.o_out_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    bus.i_out_ready = 1'b0;
    tick;
    resetn = 1'b1;
    tick;
    check("post_reset_idle", 64'(bus.o_busy), 64'd0);
    run(3'd1, 15, 9, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
